alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the core's combinational 16-bit ALU.
- Same 3-bit operation set, generalised to WIDTH bits.
- Adds registered result and status flags, and an iterative (1 bit/cycle) shifter so no barrel shifter is needed.
- Adds an optional iterative shift-add multiplier.
- Sits between the decode/register-read stage and writeback; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH)+1, width of the internal shift/iteration counter (localparam, not overridable).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request (IDLE only)
- op  in  3  operation code (see Behaviour)
- a  in  WIDTH  operand 1
- b  in  WIDTH  operand 2 (two's-complement shift amount for op 000)
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- flag_z  out  1  result == 0
- flag_n  out  1  result[WIDTH-1]
- flag_c  out  1  carry/borrow/last-shifted-out/multiply-overflow
- busy  out  1  high in SHIFT or MUL state

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: rst_n sampled low on a rising clk edge forces state=IDLE.
- Reset values: result=0, all flags=0, out_valid=0, busy=0, in_ready=1 (first cycle after reset).
- Reset mid-operation aborts the operation; no result is produced.
- Accept: a request is accepted on a rising edge with in_valid&in_ready; a, b and op are latched that cycle.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE: in_ready=1. On accept, go to DONE (single-cycle ops), SHIFT (op 000) or MUL (op 001, feature enabled).
  - DONE: out_valid=1, in_ready=0. result and flags held stable until out_ready=1, then go to IDLE.
  - No overlap: the next accept happens at the earliest one cycle after the out_ready handshake.
- op 100 ADD: result=a+b. flag_c=carry out of bit WIDTH-1. Latency 1 (out_valid on the cycle after accept).
- op 010 SUB: result=a-b. flag_c=borrow (a<b unsigned). Latency 1.
- op 101 AND, 110 OR: bitwise. flag_c=0. Latency 1.
- op 111 NOT: result=~a. b is ignored. flag_c=0. Latency 1.
- op 011: reserved. result=0, flag_z=1, flag_c=0. Latency 1.
- op 000 SHIFT:
  - b[WIDTH-1]=0: logical left shift by k=b. b[WIDTH-1]=1: logical right shift by k=-b (two's-complement magnitude).
  - k is clamped to WIDTH.
  - SHIFT moves one bit per cycle and decrements the counter. out_valid occurs 1+k cycles after accept; k=0 gives latency 1, result=a, flag_c=0.
  - flag_c = the last bit shifted out. k>=WIDTH gives result 0.
  - b = most-negative value (magnitude overflow) is treated as k=WIDTH.
- op 001: see Optional Feature.
- Flags: flag_z and flag_n are computed from the final result and registered together with it.
- Upstream protocol: in_valid may drop without acceptance (no obligation to hold); operands are sampled only on accept.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: op 001 is an unsigned shift-add multiply, one multiplier bit per cycle.
  - MUL lasts WIDTH cycles; out_valid occurs WIDTH+1 cycles after accept.
  - result = low WIDTH bits of a*b. flag_c=1 if the high WIDTH bits are nonzero.
- Undefined: op 001 behaves as reserved (result 0, flag_z=1, latency 1). The MUL state and the 2*WIDTH accumulator are not synthesised.

Decomposition:
- Package alu_seq_pkg holds:
  - op-code constants: OP_SHIFT=3'b000, OP_MUL=3'b001, OP_SUB=3'b010, OP_RSV=3'b011, OP_ADD=3'b100, OP_AND=3'b101, OP_OR=3'b110, OP_NOT=3'b111
  - FSM state enum: IDLE, SHIFT, MUL, DONE
- Sub-module alu_seq_logic: purely combinational single-cycle ADD/SUB/AND/OR/NOT with carry output. The top level owns the FSM, the shift/multiply datapath and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, in_ready=1 after release. Reset asserted during an 8-cycle shift -> IDLE next edge, no out_valid.
- ADD, WIDTH=16: a=16'hFFFF, b=16'h0001 -> out_valid 1 cycle after accept, result=0, flag_z=1, flag_c=1. SUB a=3, b=5 -> 16'hFFFE, flag_n=1, flag_c=1.
- SHIFT: a=16'h8001, b=1 -> 16'h0002, flag_c=1, latency 2. b=16'hFFFC (right 4), a=16'h00F8 -> 16'h000F, flag_c=1, latency 5. b=20 -> result 0, latency 17.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0. Then out_ready=1 -> in_ready=1 on the next cycle.
- MUL with ALU_SEQ_MUL_EN: a=300, b=300 -> result=16'h5F90, flag_c=1, latency 17. a=7, b=9 -> 63, flag_c=0. Without the macro: op 001 -> result 0, flag_z=1, latency 1.
- Random back-to-back ops with random in_valid/out_ready against a reference model -> all results and flags match, no dropped or duplicated transactions.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op-code constants and FSM state type for alu_seq.
// Optional feature macro used by importers: ALU_SEQ_MUL_EN.
package alu_seq_pkg;

  localparam logic [2:0] OP_SHIFT = 3'b000;
  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_RSV   = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_NOT   = 3'b111;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;

endpackage

// File: rtl/alu_seq_logic.sv
// alu_seq_logic: combinational single-cycle ADD/SUB/AND/OR/NOT.
// Ports:
//   op    - operation code
//   a, b  - operands
//   res   - result (0 for any op not handled here)
//   carry - ADD carry out / SUB borrow, 0 otherwise
module alu_seq_logic
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             carry
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext   = '0;
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        res   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OP_SUB: begin
        // top bit of the zero-extended difference is the borrow (a < b)
        ext   = {1'b0, a} - {1'b0, b};
        res   = ext[WIDTH-1:0];
        carry = ext[WIDTH];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOT:  res = ~a;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags, a 1-bit/cycle
// shifter and an optional shift-add multiplier (enable with the macro
// ALU_SEQ_MUL_EN; without it op 001 behaves as the reserved op).
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid/in_ready    - request handshake (ready only in IDLE)
//   op, a, b             - operation and operands, latched on accept
//   out_valid/out_ready  - result handshake (valid in DONE)
//   result, flag_z/n/c   - registered result and status flags
//   busy                 - shift or multiply in progress
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] W_V = WIDTH'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             z_q, z_d, n_q, n_d, c_q, c_d;
  logic [WIDTH-1:0] wk_q, wk_d;     // shift operand, or multiplicand
  logic [SHW-1:0]   cnt_q, cnt_d;   // remaining steps
  logic             dir_q, dir_d;   // 1 = shift right

  logic [WIDTH-1:0] lg_res;
  logic             lg_c;
  logic [WIDTH-1:0] mag;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_out;
  logic             ld;
  logic [WIDTH-1:0] res_new;
  logic             c_new;

`ifdef ALU_SEQ_MUL_EN
  // {high, low} product register; low half starts as the multiplier and
  // is consumed from bit 0 while the partial product shifts in from above
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [WIDTH:0]     mul_sum;
`endif

  alu_seq_logic #(.WIDTH(WIDTH)) u_logic (
    .op    (op),
    .a     (a),
    .b     (b),
    .res   (lg_res),
    .carry (lg_c)
  );

  // Negative b means shift right by -b; the most-negative value negates to
  // itself, which is >= WIDTH and so clamps like any oversize amount.
  always_comb begin
    mag = b[WIDTH-1] ? (-b) : b;
    k   = (mag >= W_V) ? SHW'(WIDTH) : SHW'(mag);
  end

  always_comb begin
    sh_nxt = dir_q ? {1'b0, wk_q[WIDTH-1:1]} : {wk_q[WIDTH-2:0], 1'b0};
    sh_out = dir_q ? wk_q[0] : wk_q[WIDTH-1];
  end

`ifdef ALU_SEQ_MUL_EN
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, wk_q} : '0);
    acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    wk_d    = wk_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    res_d   = res_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    ld      = 1'b0;
    res_new = '0;
    c_new   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (op)
            OP_SHIFT: begin
              if (k == '0) begin
                ld      = 1'b1;
                res_new = a;
                state_d = DONE;
              end else begin
                wk_d    = a;
                cnt_d   = k;
                dir_d   = b[WIDTH-1];
                state_d = SHIFT;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              wk_d    = a;
              acc_d   = {{WIDTH{1'b0}}, b};
              cnt_d   = SHW'(WIDTH);
              state_d = MUL;
            end
`endif
            default: begin
              ld      = 1'b1;
              res_new = lg_res;
              c_new   = lg_c;
              state_d = DONE;
            end
          endcase
        end
      end
      SHIFT: begin
        wk_d  = sh_nxt;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          ld      = 1'b1;
          res_new = sh_nxt;
          c_new   = sh_out;
          state_d = DONE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          ld      = 1'b1;
          res_new = acc_nxt[WIDTH-1:0];
          c_new   = |acc_nxt[2*WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // flags only move when a new result is loaded
    if (ld) begin
      res_d = res_new;
      c_d   = c_new;
      z_d   = ~|res_new;
      n_d   = res_new[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      wk_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      wk_q    <= wk_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == MUL);
  assign result    = res_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    int           lat;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, busy;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled
  exp_t sbq[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic c, input int lat);
    exp_t e;
    e.res = r; e.c = c; e.lat = lat; e.acc_cyc = 0;
    return e;
  endfunction

  // reference model: plain arithmetic on the architectural definition
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint p;
    int     k;
    e = mk('0, 1'b0, 1);
    case (o)
      OP_ADD: begin p = longint'(x) + longint'(y); e.res = p[W-1:0]; e.c = p[W]; end
      OP_SUB: begin p = longint'(x) - longint'(y); e.res = p[W-1:0]; e.c = (x < y); end
      OP_AND: e.res = x & y;
      OP_OR:  e.res = x | y;
      OP_NOT: e.res = ~x;
      OP_SHIFT: begin
        k = y[W-1] ? ((1 << W) - int'(y)) : int'(y);
        if (k > W) k = W;
        e.lat = 1 + k;
        if (k == 0) e.res = x;
        else if (!y[W-1]) begin
          p = longint'(x) << k; e.res = p[W-1:0]; e.c = p[W];
        end else begin
          e.res = x >> k; e.c = x[k-1];
        end
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: begin
        p = longint'(x) * longint'(y);
        e.res = p[W-1:0]; e.c = ((p >> W) != 0); e.lat = W + 1;
      end
`endif
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
    int n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc + 1;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      chk("drain_timeout", 64'(sbq.size()), 64'(0));
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  // monitor: compares every presented result against the scoreboard head
  logic         fresh = 1'b1;
  logic [W-1:0] h_res;
  logic         h_z, h_n, h_c;
  always @(negedge clk) begin
    if (!rst_n) fresh = 1'b1;
    else if (out_valid) begin
      if (sbq.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'(0));
      else begin
        if (fresh) begin
          chk("latency", 64'(cyc - sbq[0].acc_cyc + 1), 64'(sbq[0].lat));
          chk("result", 64'(result), 64'(sbq[0].res));
          chk("flag_z", 64'(flag_z), 64'(sbq[0].res == '0));
          chk("flag_n", 64'(flag_n), 64'(sbq[0].res[W-1]));
          chk("flag_c", 64'(flag_c), 64'(sbq[0].c));
          h_res = result; h_z = flag_z; h_n = flag_n; h_c = flag_c;
          fresh = 1'b0;
        end else begin
          chk("held_result", 64'(result), 64'(h_res));
          chk("held_flags", 64'({flag_z, flag_n, flag_c}), 64'({h_z, h_n, h_c}));
        end
        chk("in_ready_in_done", 64'(in_ready), 64'(0));
        if (out_ready) begin
          void'(sbq.pop_front());
          fresh = 1'b1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]   o;
    logic [W-1:0] x, y;
    rst_n = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 16'd1; b = 16'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_flags", 64'({flag_z, flag_n, flag_c}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_out_valid", 64'(out_valid), 64'(0));

    // directed vectors with hand-derived expectations
    issue(OP_ADD,   16'hFFFF, 16'h0001, mk(16'h0000, 1'b1, 1));
    issue(OP_SUB,   16'd3,    16'd5,    mk(16'hFFFE, 1'b1, 1));
    issue(OP_SHIFT, 16'h8001, 16'd1,    mk(16'h0002, 1'b1, 2));
    issue(OP_SHIFT, 16'h00F8, 16'hFFFC, mk(16'h000F, 1'b1, 5));
    issue(OP_SHIFT, 16'h1235, 16'd20,   mk(16'h0000, 1'b1, 17));
    issue(OP_SHIFT, 16'hC000, 16'h8000, mk(16'h0000, 1'b1, 17));
    issue(OP_SHIFT, 16'hABCD, 16'd0,    mk(16'hABCD, 1'b0, 1));
    issue(OP_AND,   16'hF0F0, 16'h3C3C, mk(16'h3030, 1'b0, 1));
    issue(OP_OR,    16'hF000, 16'h000F, mk(16'hF00F, 1'b0, 1));
    issue(OP_NOT,   16'h00FF, 16'h1234, mk(16'hFF00, 1'b0, 1));
    issue(OP_RSV,   16'h1234, 16'h5678, mk(16'h0000, 1'b0, 1));
`ifdef ALU_SEQ_MUL_EN
    issue(OP_MUL,   16'd300,  16'd300,  mk(16'h5F90, 1'b1, 17));
    issue(OP_MUL,   16'd7,    16'd9,    mk(16'd63,   1'b0, 17));
`else
    issue(OP_MUL,   16'd300,  16'd300,  mk(16'h0000, 1'b0, 1));
`endif
    drain();

    // backpressure: result held while the consumer stalls
    rdy_mode = 2;
    issue(OP_ADD, 16'd5, 16'd6, mk(16'd11, 1'b0, 1));
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'(1));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
    end
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'(1));
    chk("bp_release_out_valid", 64'(out_valid), 64'(0));
    drain();

    // reset during an 8-step shift aborts it
    issue(OP_SHIFT, 16'h00FF, 16'd8, mk(16'hFF00, 1'b0, 9));
    repeat (3) @(negedge clk);
    chk("shift_busy", 64'(busy), 64'(1));
    sbq.delete();
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_result", 64'(result), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_output", 64'(out_valid), 64'(0));
    end

    // random traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 7));
      x = W'($urandom);
      case ($urandom_range(0, 3))
        0:       y = W'($urandom_range(0, 20));
        1:       y = -W'($urandom_range(0, 20));
        2:       y = 16'h8000;
        default: y = W'($urandom);
      endcase
      issue(o, x, y, model(o, x, y));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
